// File: rtl/decim_pkg.sv
// Shared types and defaults for the bitstream decimator sequencing controller.
package decim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } decim_state_e;

  localparam int NUM_DEF    = 11;
  localparam int DEN_DEF    = 16;
  localparam int WARMUP_DEF = 8;

  // One extra bit so acc + NUM (< 2*DEN) never overflows.
  function automatic int acc_w(input int den);
    return $clog2(den) + 1;
  endfunction

endpackage

// File: rtl/decim_ctrl_if.sv
// Run control, filter gating and sample valid/ready bundle of decim_ctrl.
// master: the controller; slave: the surrounding filter/consumer side.
interface decim_ctrl_if;
  logic        en;
  logic        tap_stb;
  logic        dec_stb;
  logic [7:0]  filt_out;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clr_ovr;
  logic        busy;
  logic [15:0] sample_cnt;
  logic [15:0] drop_cnt;

  modport master (
    input  en, filt_out, out_ready, clr_ovr,
    output tap_stb, dec_stb, out_data, out_valid, overrun, busy, sample_cnt, drop_cnt
  );

  modport slave (
    output en, filt_out, out_ready, clr_ovr,
    input  tap_stb, dec_stb, out_data, out_valid, overrun, busy, sample_cnt, drop_cnt
  );
endinterface

// File: rtl/frac_rate_gen.sv
// Phase accumulator producing NUM evenly spread strobes per DEN enabled cycles.
module frac_rate_gen
  import decim_pkg::*;
#(
  parameter int NUM = NUM_DEF,
  parameter int DEN = DEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic stb
);

  localparam int ACC_W = acc_w(DEN);
  localparam logic [ACC_W-1:0] NUM_C = ACC_W'(NUM);
  localparam logic [ACC_W-1:0] DEN_C = ACC_W'(DEN);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;

  // Held at zero while disabled so every start replays the same pattern.
  always_comb begin
    sum   = acc_q + NUM_C;
    stb   = en && (sum >= DEN_C);
    acc_d = '0;
    if (en) begin
      acc_d = stb ? (sum - DEN_C) : sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/decim_ctrl.sv
// Sequencing controller for the 1-bit bitstream filter/decimator (16->11 rate change).
// Optional statistics counters are built when DECIM_CTRL_STATS_EN is defined.
module decim_ctrl
  import decim_pkg::*;
#(
  parameter int NUM    = NUM_DEF,
  parameter int DEN    = DEN_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  decim_ctrl_if.master bus
);

  if (NUM < 1 || NUM >= DEN || WARMUP < 0) begin : g_param_check
    $error("decim_ctrl: requires 1 <= NUM < DEN and WARMUP >= 0");
  end

  localparam int WCNT_W = $clog2(WARMUP + 2);

  decim_state_e      state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              active;
  logic              stb;
  logic              load;
  logic              drop;

  assign active = (state_q != ST_IDLE);

  frac_rate_gen #(
    .NUM (NUM),
    .DEN (DEN)
  ) u_rate (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active),
    .stb   (stb)
  );

  always_comb begin
    load        = stb && (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    drop        = stb && (state_q == ST_RUN) && out_valid_q && !bus.out_ready;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    out_data_d  = load ? bus.filt_out : out_data_q;
    out_valid_d = load ? 1'b1 : ((out_valid_q && bus.out_ready) ? 1'b0 : out_valid_q);
    overrun_d   = drop ? 1'b1 : (bus.clr_ovr ? 1'b0 : overrun_q);

    case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (bus.en) begin
          state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
        end else if (stb) begin
          if (wcnt_q == WCNT_W'(WARMUP - 1)) begin
            state_d = ST_RUN;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.tap_stb   = active;
  assign bus.busy      = active;
  assign bus.dec_stb   = stb;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;

`ifdef DECIM_CTRL_STATS_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating: a stuck-at-max count is more honest than a wrapped one.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (load && sample_cnt_q != 16'hFFFF) begin
      sample_cnt_d = sample_cnt_q + 16'd1;
    end
    if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.sample_cnt = sample_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
`else
  assign bus.sample_cnt = '0;
  assign bus.drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_decim_ctrl.sv
// Bench for decim_ctrl: two instances (no warm-up and 8-strobe warm-up) driven
// with identical stimulus and compared every cycle against a rate-formula model.
module tb_decim_ctrl;
  import decim_pkg::*;

  localparam int NUM = 11;
  localparam int DEN = 16;
`ifdef DECIM_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, out_ready, clr_ovr;
  logic [7:0] filt_out;

  always #5 clk = ~clk;

  decim_ctrl_if if0 ();
  decim_ctrl_if if1 ();

  assign if0.en = en;  assign if0.out_ready = out_ready;
  assign if0.clr_ovr = clr_ovr;  assign if0.filt_out = filt_out;
  assign if1.en = en;  assign if1.out_ready = out_ready;
  assign if1.clr_ovr = clr_ovr;  assign if1.filt_out = filt_out;

  decim_ctrl #(.NUM(NUM), .DEN(DEN), .WARMUP(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  decim_ctrl #(.NUM(NUM), .DEN(DEN), .WARMUP(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic        o_stb [2], o_tap [2], o_busy [2], o_vld [2], o_ovr [2];
  logic [7:0]  o_data [2];
  logic [15:0] o_scnt [2], o_dcnt [2];

  assign o_stb[0]  = if0.dec_stb;    assign o_stb[1]  = if1.dec_stb;
  assign o_tap[0]  = if0.tap_stb;    assign o_tap[1]  = if1.tap_stb;
  assign o_busy[0] = if0.busy;       assign o_busy[1] = if1.busy;
  assign o_vld[0]  = if0.out_valid;  assign o_vld[1]  = if1.out_valid;
  assign o_ovr[0]  = if0.overrun;    assign o_ovr[1]  = if1.overrun;
  assign o_data[0] = if0.out_data;   assign o_data[1] = if1.out_data;
  assign o_scnt[0] = if0.sample_cnt; assign o_scnt[1] = if1.sample_cnt;
  assign o_dcnt[0] = if0.drop_cnt;   assign o_dcnt[1] = if1.drop_cnt;

  // Model: k = cycles since start, nstb = strobes since start.
  bit         m_busy [2], m_vld [2], m_ovr [2];
  logic [7:0] m_data [2];
  int         m_k [2], m_nstb [2], m_scnt [2], m_dcnt [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int warm_of(input int d);
    return (d == 0) ? 0 : 8;
  endfunction

  // Strobe whenever floor(k*NUM/DEN) steps up across cycle k.
  function automatic bit exp_stb(input int d);
    return m_busy[d] && ((((m_k[d] + 1) * NUM) / DEN) != ((m_k[d] * NUM) / DEN));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_vld[d] = 0; m_ovr[d] = 0; m_data[d] = 8'h00;
      m_k[d] = 0; m_nstb[d] = 0; m_scnt[d] = 0; m_dcnt[d] = 0;
    end
  endtask

  task automatic check_outputs(input string ph);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s.d%0d.dec_stb", ph, d), 32'(o_stb[d]), 32'(exp_stb(d)));
      check_eq($sformatf("%s.d%0d.tap_stb", ph, d), 32'(o_tap[d]), 32'(m_busy[d]));
      check_eq($sformatf("%s.d%0d.busy", ph, d), 32'(o_busy[d]), 32'(m_busy[d]));
      check_eq($sformatf("%s.d%0d.out_valid", ph, d), 32'(o_vld[d]), 32'(m_vld[d]));
      check_eq($sformatf("%s.d%0d.out_data", ph, d), 32'(o_data[d]), 32'(m_data[d]));
      check_eq($sformatf("%s.d%0d.overrun", ph, d), 32'(o_ovr[d]), 32'(m_ovr[d]));
      check_eq($sformatf("%s.d%0d.sample_cnt", ph, d), 32'(o_scnt[d]), STATS ? 32'(m_scnt[d]) : 32'd0);
      check_eq($sformatf("%s.d%0d.drop_cnt", ph, d), 32'(o_dcnt[d]), STATS ? 32'(m_dcnt[d]) : 32'd0);
    end
  endtask

  task automatic model_step(input int d, input bit e, input bit rdy, input bit clr, input logic [7:0] f);
    bit s, live, ld, dr, xfer;
    s    = exp_stb(d);
    live = s && m_busy[d] && (m_nstb[d] >= warm_of(d));
    ld   = live && (!m_vld[d] || rdy);
    dr   = live && m_vld[d] && !rdy;
    xfer = m_vld[d] && rdy;
    if (ld) m_data[d] = f;
    m_vld[d] = ld ? 1'b1 : (xfer ? 1'b0 : m_vld[d]);
    m_ovr[d] = dr ? 1'b1 : (clr ? 1'b0 : m_ovr[d]);
    if (ld && m_scnt[d] < 65535) m_scnt[d]++;
    if (dr && m_dcnt[d] < 65535) m_dcnt[d]++;
    if (m_busy[d]) begin
      m_nstb[d] += int'(s);
      m_k[d]++;
      if (!e) begin m_busy[d] = 0; m_k[d] = 0; m_nstb[d] = 0; end
    end else if (e) begin
      m_busy[d] = 1; m_k[d] = 0; m_nstb[d] = 0;
    end
  endtask

  // Entered and left at posedge+1; outputs checked mid-cycle.
  task automatic cycle(input bit e, input bit rdy, input bit clr, input logic [7:0] f, output bit stb0);
    en = e; out_ready = rdy; clr_ovr = clr; filt_out = f;
    #3;
    check_outputs("cyc");
    stb0 = o_stb[0];
    for (int d = 0; d < 2; d++) model_step(d, e, rdy, clr, f);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int  nst;
    bit  s;
    bit  seen;
    logic [7:0] first_data;
    bit  e_r;

    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0; filt_out = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    rst_n = 1'b1;

    // Continuous run, ramping filter word, always-ready consumer.
    nst = 0; seen = 0; first_data = 8'h00;
    for (int i = 0; i < 161; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'(i), s);
      nst += int'(s);
      if (!seen && o_vld[1]) begin seen = 1; first_data = o_data[1]; end
    end
    check_eq("stb_count_160", 32'(nst), 32'd110);
    check_eq("sample_cnt_160", 32'(o_scnt[0]), STATS ? 32'd110 : 32'd0);
    check_eq("warmup_first_data", 32'(first_data), 32'd14);

    repeat (3) cycle(1'b0, 1'b1, 1'b0, 8'h00, s);

    // Stalled consumer: overruns, then EN drop with a word pending.
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom), s);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'($urandom), s);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, s);
    check_eq("ovr_cleared", 32'(o_ovr[0]), 32'd0);
    check_eq("pending_hold", 32'(o_vld[0]), 32'd1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, s);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, s);
    check_eq("pending_taken", 32'(o_vld[0]), 32'd0);

    // Restart replays the phase pattern from c0.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 8'($urandom), s);

    // Asynchronous reset with a word pending, then resume.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom), s);
    async_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 8'($urandom), s);

    // Random traffic with occasional EN toggles and clears.
    e_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) e_r = ~e_r;
      cycle(e_r, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 5), 8'($urandom), s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
